// File: rtl/countdown_timer_pkg.sv
// Shared definitions for the countdown timer: state encoding and default width.
package countdown_timer_pkg;

    localparam int DEFAULT_WIDTH = 8;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    typedef enum logic [1:0] {
        S_IDLE = ST_IDLE,
        S_RUN  = ST_RUN,
        S_DONE = ST_DONE
    } state_e;

endpackage

// File: rtl/countdown_timer.sv
// Programmable down-counting timer with one-shot and auto-reload modes.
// Counts down on tick while running; expiry at zero emits a one-cycle tc pulse
// and either reloads (auto_reload) or parks in DONE with count held at zero.
// Per-cycle priority: load > stop > start > tick.
module countdown_timer
    import countdown_timer_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             start,
    input  logic             stop,
    input  logic             tick,
    input  logic             auto_reload,
    output logic [WIDTH-1:0] count,
    output logic             tc,
    output logic             busy,
    output logic             done
);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] count_q, count_d;
    logic [WIDTH-1:0] reload_q, reload_d;
    logic             tc_q, tc_d;

    // State, count, reload value and terminal-count pulse registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            count_q  <= '0;
            reload_q <= '0;
            tc_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            reload_q <= reload_d;
            tc_q     <= tc_d;
        end
    end

    // Next-state and datapath decode; load overrides everything else.
    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        reload_d = reload_q;
        tc_d     = 1'b0;

        if (load) begin
            count_d  = load_val;
            reload_d = load_val;
            state_d  = S_IDLE;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    // stop outranks start, so both together leave us idle
                    if (!stop && start) begin
                        state_d = S_RUN;
                    end
                end
                S_RUN: begin
                    if (stop) begin
                        state_d = S_IDLE;
                    end else if (tick) begin
                        if (count_q != '0) begin
                            count_d = count_q - WIDTH'(1);
                        end else begin
                            // expiry: auto_reload only matters in this cycle
                            tc_d = 1'b1;
                            if (auto_reload) begin
                                count_d = reload_q;
                            end else begin
                                state_d = S_DONE;
                            end
                        end
                    end
                end
                S_DONE: begin
                    if (!stop && start) begin
                        count_d = reload_q;
                        state_d = S_RUN;
                    end
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    assign count = count_q;
    assign tc    = tc_q;
    assign busy  = (state_q == S_RUN);
    assign done  = (state_q == S_DONE);

endmodule

// File: tb/tb_countdown_timer.sv
// Directed bench for countdown_timer: reset, one-shot, auto-reload,
// stop/resume, input priority and zero/restart boundaries.
module tb_countdown_timer;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         load = 1'b0;
    logic [W-1:0] load_val = '0;
    logic         start = 1'b0;
    logic         stop = 1'b0;
    logic         tick = 1'b0;
    logic         auto_reload = 1'b0;
    logic [W-1:0] count;
    logic         tc;
    logic         busy;
    logic         done;

    int checks = 0;
    int failures = 0;

    countdown_timer #(.WIDTH(W)) dut (
        .clk        (clk),
        .rst        (rst),
        .load       (load),
        .load_val   (load_val),
        .start      (start),
        .stop       (stop),
        .tick       (tick),
        .auto_reload(auto_reload),
        .count      (count),
        .tc         (tc),
        .busy       (busy),
        .done       (done)
    );

    always #5 clk = ~clk;

    // Apply inputs for one clock, then settle 1 time unit past the edge.
    task automatic cycle(input logic l, input logic [W-1:0] v, input logic s,
                         input logic p, input logic t);
        load = l; load_val = v; start = s; stop = p; tick = t;
        @(posedge clk);
        #1;
        load = 1'b0; start = 1'b0; stop = 1'b0; tick = 1'b0;
    endtask

    task automatic test_reset();
        #2;
        checks++;
        if (count !== 8'd0 || tc !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
            failures++;
            $display("FAIL reset_state: count=%0d tc=%b busy=%b done=%b expected 0 0 0 0",
                     count, tc, busy, done);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_one_shot();
        logic [W-1:0] exp_cnt [4] = '{8'd2, 8'd1, 8'd0, 8'd0};
        auto_reload = 1'b0;
        cycle(1'b1, 8'd3, 1'b0, 1'b0, 1'b0);
        checks++;
        if (count !== 8'd3 || busy !== 1'b0) begin
            failures++;
            $display("FAIL oneshot_load: count=%0d busy=%b expected 3 0", count, busy);
        end
        cycle(1'b0, 8'd0, 1'b1, 1'b0, 1'b0);
        checks++;
        if (count !== 8'd3 || busy !== 1'b1) begin
            failures++;
            $display("FAIL oneshot_start: count=%0d busy=%b expected 3 1", count, busy);
        end
        for (int i = 0; i < 4; i++) begin
            cycle(1'b0, 8'd0, 1'b0, 1'b0, 1'b1);
            checks++;
            if (count !== exp_cnt[i] || tc !== (i == 3) || busy !== (i != 3) || done !== (i == 3)) begin
                failures++;
                $display("FAIL oneshot_tick%0d: count=%0d tc=%b busy=%b done=%b expected %0d %b %b %b",
                         i, count, tc, busy, done, exp_cnt[i], (i == 3), (i != 3), (i == 3));
            end
        end
        cycle(1'b0, 8'd0, 1'b0, 1'b0, 1'b1);
        checks++;
        if (tc !== 1'b0 || done !== 1'b1 || count !== 8'd0) begin
            failures++;
            $display("FAIL oneshot_after: tc=%b done=%b count=%0d expected 0 1 0", tc, done, count);
        end
    endtask

    task automatic test_auto_reload();
        logic [W-1:0] exp_cnt [9] = '{8'd1, 8'd0, 8'd2, 8'd1, 8'd0, 8'd2, 8'd1, 8'd0, 8'd2};
        int pulses = 0;
        auto_reload = 1'b1;
        cycle(1'b1, 8'd2, 1'b0, 1'b0, 1'b0);
        cycle(1'b0, 8'd0, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 9; i++) begin
            cycle(1'b0, 8'd0, 1'b0, 1'b0, 1'b1);
            if (tc === 1'b1) pulses++;
            checks++;
            if (count !== exp_cnt[i] || tc !== (i % 3 == 2) || busy !== 1'b1) begin
                failures++;
                $display("FAIL auto_tick%0d: count=%0d tc=%b busy=%b expected %0d %b 1",
                         i, count, tc, busy, exp_cnt[i], (i % 3 == 2));
            end
        end
        checks++;
        if (pulses != 3) begin
            failures++;
            $display("FAIL auto_pulses: got %0d expected 3", pulses);
        end
        auto_reload = 1'b0;
    endtask

    task automatic test_stop_resume();
        cycle(1'b1, 8'd10, 1'b0, 1'b0, 1'b0);
        cycle(1'b0, 8'd0, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) cycle(1'b0, 8'd0, 1'b0, 1'b0, 1'b1);
        checks++;
        if (count !== 8'd6) begin
            failures++;
            $display("FAIL stop_pre: count=%0d expected 6", count);
        end
        cycle(1'b0, 8'd0, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 5; i++) cycle(1'b0, 8'd0, 1'b0, 1'b0, 1'b1);
        checks++;
        if (count !== 8'd6 || busy !== 1'b0) begin
            failures++;
            $display("FAIL stop_hold: count=%0d busy=%b expected 6 0", count, busy);
        end
        cycle(1'b0, 8'd0, 1'b1, 1'b0, 1'b0);
        cycle(1'b0, 8'd0, 1'b0, 1'b0, 1'b1);
        checks++;
        if (count !== 8'd5 || busy !== 1'b1) begin
            failures++;
            $display("FAIL stop_resume: count=%0d busy=%b expected 5 1", count, busy);
        end
    endtask

    task automatic test_priority();
        cycle(1'b1, 8'd8, 1'b0, 1'b0, 1'b0);
        cycle(1'b0, 8'd0, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) cycle(1'b0, 8'd0, 1'b0, 1'b0, 1'b1);
        checks++;
        if (count !== 8'd4 || busy !== 1'b1) begin
            failures++;
            $display("FAIL prio_setup: count=%0d busy=%b expected 4 1", count, busy);
        end
        cycle(1'b1, 8'd7, 1'b1, 1'b0, 1'b1);
        checks++;
        if (count !== 8'd7 || busy !== 1'b0 || done !== 1'b0) begin
            failures++;
            $display("FAIL prio_load: count=%0d busy=%b done=%b expected 7 0 0", count, busy, done);
        end
        cycle(1'b0, 8'd0, 1'b1, 1'b1, 1'b0);
        checks++;
        if (busy !== 1'b0 || count !== 8'd7) begin
            failures++;
            $display("FAIL prio_stop_start: busy=%b count=%0d expected 0 7", busy, count);
        end
        cycle(1'b0, 8'd0, 1'b0, 1'b0, 1'b1);
        checks++;
        if (count !== 8'd7 || tc !== 1'b0) begin
            failures++;
            $display("FAIL prio_idle_tick: count=%0d tc=%b expected 7 0", count, tc);
        end
    endtask

    task automatic test_boundary();
        auto_reload = 1'b1;
        cycle(1'b1, 8'd0, 1'b0, 1'b0, 1'b0);
        cycle(1'b0, 8'd0, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            cycle(1'b0, 8'd0, 1'b0, 1'b0, 1'b1);
            checks++;
            if (tc !== 1'b1 || count !== 8'd0 || busy !== 1'b1) begin
                failures++;
                $display("FAIL zero_reload%0d: tc=%b count=%0d busy=%b expected 1 0 1",
                         i, tc, count, busy);
            end
        end
        auto_reload = 1'b0;
        cycle(1'b1, 8'd5, 1'b0, 1'b0, 1'b0);
        cycle(1'b0, 8'd0, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 6; i++) cycle(1'b0, 8'd0, 1'b0, 1'b0, 1'b1);
        checks++;
        if (done !== 1'b1 || tc !== 1'b1 || count !== 8'd0) begin
            failures++;
            $display("FAIL restart_expiry: done=%b tc=%b count=%0d expected 1 1 0", done, tc, count);
        end
        cycle(1'b0, 8'd0, 1'b1, 1'b0, 1'b0);
        checks++;
        if (count !== 8'd5 || busy !== 1'b1 || done !== 1'b0 || tc !== 1'b0) begin
            failures++;
            $display("FAIL restart_done: count=%0d busy=%b done=%b tc=%b expected 5 1 0 0",
                     count, busy, done, tc);
        end
    endtask

    task automatic test_reset_mid_run();
        auto_reload = 1'b1;
        cycle(1'b1, 8'd7, 1'b0, 1'b0, 1'b0);
        cycle(1'b0, 8'd0, 1'b1, 1'b0, 1'b0);
        cycle(1'b0, 8'd0, 1'b0, 1'b0, 1'b1);
        cycle(1'b0, 8'd0, 1'b0, 1'b0, 1'b1);
        checks++;
        if (count !== 8'd5 || busy !== 1'b1) begin
            failures++;
            $display("FAIL midrst_setup: count=%0d busy=%b expected 5 1", count, busy);
        end
        tick = 1'b1;
        rst = 1'b1;
        #1;
        checks++;
        if (count !== 8'd0 || busy !== 1'b0 || done !== 1'b0 || tc !== 1'b0) begin
            failures++;
            $display("FAIL midrst_async: count=%0d busy=%b done=%b tc=%b expected 0 0 0 0",
                     count, busy, done, tc);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        tick = 1'b0;
        cycle(1'b0, 8'd0, 1'b1, 1'b0, 1'b0);
        cycle(1'b0, 8'd0, 1'b0, 1'b0, 1'b1);
        checks++;
        if (tc !== 1'b1 || count !== 8'd0) begin
            failures++;
            $display("FAIL midrst_reload_cleared: tc=%b count=%0d expected 1 0", tc, count);
        end
        auto_reload = 1'b0;
    endtask

    initial begin
        test_reset();
        test_one_shot();
        test_auto_reload();
        test_stop_resume();
        test_priority();
        test_boundary();
        test_reset_mid_run();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
